wash_cycle_ctrl: RTL and testbench

Parametrised successor to the fixed-program washing machine FSM. It sequences fill, wash, rinse, spin, dry and steam-clean phases. Phase durations, time-unit prescale and counter width are parameters. The number of wash/rinse passes is a run-time input. The block adds skip-dry, abort-with-drain, and live phase/remaining-time status, and sits between the front-panel input logic and the motor/valve/heater drivers.

---
 rtl/wash_cycle_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_wash_cycle_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wash_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// wash_cycle_ctrl
//
// Sequences a washing-machine program through fill, wash/rinse passes, spin,
// optional dry, or a steam-clean-only program.
//   * Phase durations are parameters, counted in time units of TICK_DIV clocks.
//   * The run-time wash_reps input selects the number of wash/rinse passes.
//   * An abort during a wet phase drains the drum first.
//   * Phase and remaining time are reported live.
//
// Handshake: start is a level request. It is taken on any rising edge that
// sees state=IDLE and start=1, and the program begins on that same edge.
// Once busy=1, start is ignored. The cycle ends when busy returns low, with
// either done=1 (normal completion) or aborted=1.
//
// Ports
//   clk, rst    : clock (rising edge) and asynchronous active-high reset
//   start       : program request, sampled only in IDLE
//   wash_reps   : wash+rinse passes (0 behaves as 1), latched at start
//   dry_wash    : steam-clean-only program, sampled at start
//   skip_dry    : finish after SPIN, latched at start
//   time_pause  : freezes the prescaler and the phase timer
//   abort       : ends the cycle (via DRAIN when the drum holds water)
//   phase       : current state code (the FSM state itself)
//   remaining   : time units left in the current phase, 0 in IDLE
//   pass_cnt    : current wash pass (1-based), 0 in IDLE and STEAM
//   busy        : state is not IDLE
//   done        : last cycle completed normally
//   aborted     : last cycle was aborted
// -----------------------------------------------------------------------------
module wash_cycle_ctrl #(
    parameter int TICK_DIV = 1,
    parameter int CNT_W    = 16,
    parameter int FILL_T   = 60,
    parameter int WASH_T   = 300,
    parameter int RINSE_T  = 300,
    parameter int SPIN_T   = 120,
    parameter int DRY_T    = 600,
    parameter int STEAM_T  = 600,
    parameter int DRAIN_T  = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       wash_reps,
    input  logic             dry_wash,
    input  logic             skip_dry,
    input  logic             time_pause,
    input  logic             abort,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       pass_cnt,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // A duration must be at least one unit and must fit in the counter.
    function automatic bit dur_ok(input int t);
        return (t >= 1) && ((longint'(t) >> CNT_W) == 0);
    endfunction

    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("wash_cycle_ctrl: TICK_DIV must be >= 1");
    end
    if (!(dur_ok(FILL_T) && dur_ok(WASH_T) && dur_ok(RINSE_T) &&
          dur_ok(SPIN_T) && dur_ok(DRY_T) && dur_ok(STEAM_T) &&
          dur_ok(DRAIN_T))) begin : g_bad_duration
        $error("wash_cycle_ctrl: every phase duration must be in 1..2**CNT_W-1");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_SPIN  = 3'd4,
        S_DRY   = 3'd5,
        S_STEAM = 3'd6,
        S_DRAIN = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic [1:0]       pass_q, pass_d;
    logic [1:0]       reps_q, reps_d;
    logic             skip_q, skip_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             busy_q, busy_d;

    // Phase-length lookup; IDLE loads 0 so remaining reads 0 when idle.
    function automatic logic [CNT_W-1:0] dur(input state_t s);
        case (s)
            S_FILL:  return CNT_W'(FILL_T);
            S_WASH:  return CNT_W'(WASH_T);
            S_RINSE: return CNT_W'(RINSE_T);
            S_SPIN:  return CNT_W'(SPIN_T);
            S_DRY:   return CNT_W'(DRY_T);
            S_STEAM: return CNT_W'(STEAM_T);
            S_DRAIN: return CNT_W'(DRAIN_T);
            default: return '0;
        endcase
    endfunction

    logic is_idle, wet_phase, dry_phase;
    logic start_go, abort_drain, abort_idle, tick, timeout;

    always_comb begin
        is_idle     = (state_q == S_IDLE);
        wet_phase   = (state_q == S_FILL) || (state_q == S_WASH) || (state_q == S_RINSE);
        dry_phase   = (state_q == S_SPIN) || (state_q == S_DRY) || (state_q == S_STEAM);
        start_go    = is_idle && start;
        abort_drain = abort && wet_phase;
        abort_idle  = abort && dry_phase;
        tick        = !is_idle && !time_pause && (ps_q == PS_W'(TICK_DIV - 1));
        // remaining is never 0 outside IDLE, so the final unit is the timeout.
        timeout     = tick && (rem_q == CNT_W'(1));
    end

    // State register together with the registered datapath it qualifies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            ps_q      <= '0;
            pass_q    <= '0;
            reps_q    <= '0;
            skip_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            ps_q      <= ps_d;
            pass_q    <= pass_d;
            reps_q    <= reps_d;
            skip_q    <= skip_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic. Abort outranks timeout, and pause only suppresses tick.
    always_comb begin
        state_d = state_q;
        if (start_go) begin
            state_d = dry_wash ? S_STEAM : S_FILL;
        end else if (abort_drain) begin
            state_d = S_DRAIN;
        end else if (abort_idle) begin
            state_d = S_IDLE;
        end else if (timeout) begin
            case (state_q)
                S_FILL:  state_d = S_WASH;
                S_WASH:  state_d = S_RINSE;
                S_RINSE: state_d = (pass_q < reps_q) ? S_WASH : S_SPIN;
                S_SPIN:  state_d = skip_q ? S_IDLE : S_DRY;
                default: state_d = S_IDLE;  // DRY, STEAM, DRAIN
            endcase
        end
    end

    // Output/datapath logic: next values of the registered status outputs.
    always_comb begin
        rem_d     = rem_q;
        ps_d      = ps_q;
        pass_d    = pass_q;
        reps_d    = reps_q;
        skip_d    = skip_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        busy_d    = (state_d != S_IDLE);

        if (start_go) begin
            reps_d    = (wash_reps == 2'd0) ? 2'd1 : wash_reps;
            skip_d    = skip_dry;
            done_d    = 1'b0;
            aborted_d = 1'b0;
            ps_d      = '0;
            rem_d     = dur(state_d);
            pass_d    = dry_wash ? 2'd0 : 2'd1;
        end else if (abort_drain || abort_idle) begin
            aborted_d = 1'b1;
            ps_d      = '0;
            rem_d     = dur(state_d);
            if (abort_idle) begin
                pass_d = 2'd0;
            end
        end else if (timeout) begin
            ps_d  = '0;
            rem_d = dur(state_d);
            if (state_d == S_IDLE) begin
                pass_d = 2'd0;
                // A drain that finishes is the tail of an abort, not a completion.
                done_d = (state_q != S_DRAIN);
            end else if (state_q == S_RINSE && state_d == S_WASH) begin
                pass_d = pass_q + 2'd1;
            end
        end else if (tick) begin
            ps_d  = '0;
            rem_d = rem_q - CNT_W'(1);
        end else if (!is_idle && !time_pause) begin
            ps_d = ps_q + PS_W'(1);
        end
    end

    assign phase     = state_q;
    assign remaining = rem_q;
    assign pass_cnt  = pass_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wash_cycle_ctrl
//
// Directed scenarios with TICK_DIV=2, FILL=3, WASH=4, RINSE=4, SPIN=2, DRY=5,
// STEAM=6 and DRAIN=2. The start edge of each program is cycle 0.
//
// Each stimulus sequence pushes the phase transitions it expects onto exp_q.
// A record holds {phase, cycle, remaining, pass_cnt, done, aborted}.
// A monitor checks on every falling edge. Whenever phase changes, it pops one
// record and compares it with what the DUT shows.
// -----------------------------------------------------------------------------
module tb_wash_cycle_ctrl;

    localparam int CNT_W = 16;
    localparam int REC_W = 3 + 16 + CNT_W + 2 + 1 + 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic             start = 1'b0;
    logic [1:0]       wash_reps = 2'd1;
    logic             dry_wash = 1'b0;
    logic             skip_dry = 1'b0;
    logic             time_pause = 1'b0;
    logic             abort = 1'b0;
    logic [2:0]       phase;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       pass_cnt;
    logic             busy;
    logic             done;
    logic             aborted;

    wash_cycle_ctrl #(
        .TICK_DIV(2), .CNT_W(CNT_W), .FILL_T(3), .WASH_T(4), .RINSE_T(4),
        .SPIN_T(2), .DRY_T(5), .STEAM_T(6), .DRAIN_T(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .wash_reps(wash_reps),
        .dry_wash(dry_wash), .skip_dry(skip_dry), .time_pause(time_pause),
        .abort(abort), .phase(phase), .remaining(remaining),
        .pass_cnt(pass_cnt), .busy(busy), .done(done), .aborted(aborted)
    );

    int cyc = 0;
    int t0  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int chk_total = 0;
    int chk_pass  = 0;

    logic [REC_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_total++;
        if (act === exp) chk_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [REC_W-1:0] mk(input logic [2:0] ph, input int c, input int rem,
                                            input logic [1:0] pc, input logic dn, input logic ab);
        return {ph, 16'(c), CNT_W'(rem), pc, dn, ab};
    endfunction

    task automatic push_ev(input logic [2:0] ph, input int c, input int rem,
                           input logic [1:0] pc, input logic dn, input logic ab);
        exp_q.push_back(mk(ph, c, rem, pc, dn, ab));
    endtask

    // scoreboard monitor
    logic [2:0] prev_ph = 3'd0;
    always @(negedge clk) begin
        logic [REC_W-1:0] act, e;
        if (phase !== prev_ph) begin
            prev_ph = phase;
            act = {phase, 16'(cyc - t0), remaining, pass_cnt, done, aborted};
            if (exp_q.size() == 0) begin
                chk_total++;
                $display("FAIL unexpected_phase: got ph=%0d cyc=%0d rem=%0d pc=%0d done=%0d ab=%0d, expected no change",
                         phase, cyc - t0, remaining, pass_cnt, done, aborted);
            end else begin
                e = exp_q.pop_front();
                chk_total++;
                if (act === e) chk_pass++;
                else $display("FAIL phase_event: got ph=%0d cyc=%0d rem=%0d pc=%0d done=%0d ab=%0d, expected ph=%0d cyc=%0d rem=%0d pc=%0d done=%0d ab=%0d",
                              act[REC_W-1 -: 3], act[REC_W-4 -: 16], act[CNT_W+3:4], act[3:2], act[1], act[0],
                              e[REC_W-1 -: 3], e[REC_W-4 -: 16], e[CNT_W+3:4], e[3:2], e[1], e[0]);
            end
        end
    end

    // driver tasks
    task automatic start_cycle(input logic [1:0] reps, input logic dw, input logic sd);
        @(negedge clk);
        wash_reps = reps;
        dry_wash  = dw;
        skip_dry  = sd;
        start     = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
    endtask

    // Returns at the falling edge that follows edge k of the current program.
    task automatic at_rel(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while ((cyc - t0) != k && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            chk_total++;
            $display("FAIL at_rel_timeout: got cycle %0d expected %0d", cyc - t0, k);
        end
    endtask

    task automatic pulse_abort_at(input int k);
        at_rel(k - 1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
    endtask

    task automatic wait_drained(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk_total++;
            $display("FAIL drain_timeout: got %0d events pending expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // reset
        #1 rst = 1'b1;
        #1 check("reset_outputs", {phase, remaining, pass_cnt, busy, done, aborted}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_start", {phase, busy}, '0);

        // normal reps=1
        push_ev(1, 0, 3, 1, 0, 0); push_ev(2, 6, 4, 1, 0, 0); push_ev(3, 14, 4, 1, 0, 0);
        push_ev(4, 22, 2, 1, 0, 0); push_ev(5, 26, 5, 1, 0, 0); push_ev(0, 36, 0, 0, 1, 0);
        start_cycle(2'd1, 1'b0, 1'b0);
        wait_drained(200);
        repeat (5) @(negedge clk);
        check("done_holds", {done, busy, aborted, pass_cnt, remaining}, {1'b1, 1'b0, 1'b0, 2'd0, CNT_W'(0)});

        // reps=2; the start edge clears done
        push_ev(1, 0, 3, 1, 0, 0); push_ev(2, 6, 4, 1, 0, 0); push_ev(3, 14, 4, 1, 0, 0);
        push_ev(2, 22, 4, 2, 0, 0); push_ev(3, 30, 4, 2, 0, 0); push_ev(4, 38, 2, 2, 0, 0);
        push_ev(5, 42, 5, 2, 0, 0); push_ev(0, 52, 0, 0, 1, 0);
        start_cycle(2'd2, 1'b0, 1'b0);
        wait_drained(200);

        // pause for 5 edges in WASH, and change wash_reps mid-cycle
        push_ev(1, 0, 3, 1, 0, 0); push_ev(2, 6, 4, 1, 0, 0); push_ev(3, 19, 4, 1, 0, 0);
        push_ev(4, 27, 2, 1, 0, 0); push_ev(5, 31, 5, 1, 0, 0); push_ev(0, 41, 0, 0, 1, 0);
        start_cycle(2'd1, 1'b0, 1'b0);
        at_rel(3);  wash_reps = 2'd3;
        at_rel(7);  time_pause = 1'b1;
        at_rel(10); check("pause_rem_mid", remaining, 4);
        at_rel(12); check("pause_rem_end", remaining, 4);
        time_pause = 1'b0;
        wash_reps = 2'd1;
        wait_drained(200);

        // abort in WASH
        push_ev(1, 0, 3, 1, 0, 0); push_ev(2, 6, 4, 1, 0, 0);
        push_ev(7, 10, 2, 1, 0, 1); push_ev(0, 14, 0, 0, 0, 1);
        start_cycle(2'd1, 1'b0, 1'b0);
        pulse_abort_at(10);
        wait_drained(200);

        // abort in DRY
        push_ev(1, 0, 3, 1, 0, 0); push_ev(2, 6, 4, 1, 0, 0); push_ev(3, 14, 4, 1, 0, 0);
        push_ev(4, 22, 2, 1, 0, 0); push_ev(5, 26, 5, 1, 0, 0); push_ev(0, 28, 0, 0, 0, 1);
        start_cycle(2'd1, 1'b0, 1'b0);
        pulse_abort_at(28);
        wait_drained(200);

        // steam-only program with skip_dry set
        push_ev(6, 0, 6, 0, 0, 0); push_ev(0, 12, 0, 0, 1, 0);
        start_cycle(2'd2, 1'b1, 1'b1);
        wait_drained(200);

        // skip_dry
        push_ev(1, 0, 3, 1, 0, 0); push_ev(2, 6, 4, 1, 0, 0); push_ev(3, 14, 4, 1, 0, 0);
        push_ev(4, 22, 2, 1, 0, 0); push_ev(0, 26, 0, 0, 1, 0);
        start_cycle(2'd1, 1'b0, 1'b1);
        wait_drained(200);

        // asynchronous reset mid-DRY, start held high through reset
        push_ev(1, 0, 3, 1, 0, 0); push_ev(2, 6, 4, 1, 0, 0); push_ev(3, 14, 4, 1, 0, 0);
        push_ev(4, 22, 2, 1, 0, 0); push_ev(5, 26, 5, 1, 0, 0); push_ev(0, 29, 0, 0, 0, 0);
        start_cycle(2'd1, 1'b0, 1'b0);
        at_rel(28);
        #2 rst = 1'b1;
        #1 check("async_reset", {phase, remaining, pass_cnt, busy, done, aborted}, '0);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("start_under_reset", {phase, busy}, '0);
        wait_drained(20);
        push_ev(1, 0, 3, 1, 0, 0); push_ev(7, 2, 2, 1, 0, 1); push_ev(0, 6, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
        pulse_abort_at(2);
        wait_drained(200);

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
